// File: rtl/imm_pkg.sv
// Shared encodings and helpers for the handshaked ARM immediate extender.
// The rotate helper is shared so the datapath and any future checker use one definition.
package imm_pkg;

  localparam int ROT_FIELD_W = 4;
  localparam int ROT_BITS_W  = ROT_FIELD_W + 2;

  typedef enum logic [1:0] {
    IMM_DP  = 2'b00,
    IMM_MEM = 2'b01,
    IMM_BR  = 2'b10,
    IMM_FP  = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ROT  = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  localparam logic [ROT_BITS_W-1:0] ROT_FULL = 6'd32;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [ROT_BITS_W-1:0] amt);
    logic [31:0] r;
    r = (x >> amt) | (x << (ROT_FULL - amt));
    return r;
  endfunction

  function automatic logic [31:0] fp_expand(input logic [7:0] imm8);
    logic [31:0] r;
    r = {imm8[7], ~imm8[6], {5{imm8[6]}}, imm8[5:4], imm8[3:0], 19'b0};
    return r;
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational ImmSrc decode: initial value, rotate amount, step count and bad-mode flag.
// Macro FP_IMM_EN enables VFP imm8 expansion for ImmSrc=11; otherwise that mode is flagged bad.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ROT_STEP = 2
) (
  input  logic [23:0]            i_instr,
  input  logic [1:0]             i_imm_src,
  output logic [DATA_W-1:0]      o_init,
  output logic [ROT_BITS_W-1:0]  o_rot_bits,
  output logic [ROT_FIELD_W-1:0] o_n_steps,
  output logic                   o_bad
);

  localparam int CALC_W = ROT_BITS_W + 1;
  localparam logic [CALC_W-1:0] STEP_W  = CALC_W'(ROT_STEP);
  localparam logic [CALC_W-1:0] STEP_M1 = CALC_W'(ROT_STEP - 1);

  logic [ROT_BITS_W-1:0]  w_dp_rot_bits;
  logic [ROT_FIELD_W-1:0] w_dp_steps;

  // Rotate field counts pairs of bits; step count rounds up so a partial final step is allowed.
  assign w_dp_rot_bits = {1'b0, i_instr[11:8], 1'b0};
  assign w_dp_steps    = ROT_FIELD_W'(({1'b0, w_dp_rot_bits} + STEP_M1) / STEP_W);

  // Mode decode
  always_comb begin
    o_init     = '0;
    o_rot_bits = '0;
    o_n_steps  = '0;
    o_bad      = 1'b0;
    case (imm_src_e'(i_imm_src))
      IMM_DP: begin
        o_init     = DATA_W'({24'h000000, i_instr[7:0]});
        o_rot_bits = w_dp_rot_bits;
        o_n_steps  = w_dp_steps;
      end
      IMM_MEM: begin
        o_init = DATA_W'({20'h00000, i_instr[11:0]});
      end
      IMM_BR: begin
        o_init = {{(DATA_W-26){i_instr[23]}}, i_instr, 2'b00};
      end
      IMM_FP: begin
`ifdef FP_IMM_EN
        o_init = DATA_W'(fp_expand(i_instr[7:0]));
`else
        o_bad  = 1'b1;
`endif
      end
      default: begin
        o_bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_seq.sv
// Handshaked immediate extender: iterative ROT_STEP-bit rotation keeps the shifter off decode timing.
// Build macro FP_IMM_EN (consumed by imm_decode_comb) enables the float immediate mode.
module imm_extend_seq
  import imm_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ROT_STEP = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       Instr,
  input  logic [1:0]        ImmSrc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ExtImm,
  output logic              bad_mode
);

  localparam logic [ROT_BITS_W-1:0] STEP_BITS = ROT_BITS_W'(ROT_STEP);

  state_e                 r_state;
  logic [DATA_W-1:0]      r_ext;
  logic                   r_bad;
  logic                   r_out_valid;
  logic [ROT_BITS_W-1:0]  r_rem;

  logic [DATA_W-1:0]      w_init;
  logic [ROT_BITS_W-1:0]  w_rot_bits;
  logic [ROT_FIELD_W-1:0] w_n_steps;
  logic                   w_bad;
  logic                   w_accept;
  logic [ROT_BITS_W-1:0]  w_step;

  imm_decode_comb #(
    .DATA_W   (DATA_W),
    .ROT_STEP (ROT_STEP)
  ) u_decode (
    .i_instr    (Instr),
    .i_imm_src  (ImmSrc),
    .o_init     (w_init),
    .o_rot_bits (w_rot_bits),
    .o_n_steps  (w_n_steps),
    .o_bad      (w_bad)
  );

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready);
  assign w_accept  = in_valid & in_ready;
  // Final step rotates only what is left when ROT_STEP does not divide the amount.
  assign w_step    = (r_rem > STEP_BITS) ? STEP_BITS : r_rem;
  assign out_valid = r_out_valid;
  assign ExtImm    = r_ext;
  assign bad_mode  = r_bad;

  // Control FSM, result register and remaining-rotation counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ext       <= '0;
      r_bad       <= 1'b0;
      r_out_valid <= 1'b0;
      r_rem       <= '0;
    end else if (w_accept) begin
      r_ext <= w_init;
      r_bad <= w_bad;
      r_rem <= w_rot_bits;
      if (w_n_steps != '0) begin
        r_state     <= S_ROT;
        r_out_valid <= 1'b0;
      end else begin
        r_state     <= S_HOLD;
        r_out_valid <= 1'b1;
      end
    end else begin
      case (r_state)
        S_ROT: begin
          r_ext[31:0] <= rotr32(r_ext[31:0], w_step);
          r_rem       <= r_rem - w_step;
          if (r_rem == w_step) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
          end else begin
            r_state     <= S_ROT;
            r_out_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end else begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
          end
        end
        S_IDLE: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_seq.sv
// Scoreboard bench for imm_extend_seq: random and directed stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_imm_extend_seq;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          in_valid, in_ready, out_valid, bad_mode;
  logic          out_ready = 1'b1;
  logic [23:0]   Instr;
  logic [1:0]    ImmSrc;
  logic [DW-1:0] ExtImm;

  logic          in_valid8, in_ready8, out_valid8, bad8;
  logic          out_ready8 = 1'b1;
  logic [23:0]   instr8;
  logic [1:0]    src8 = 2'b00;
  logic [DW-1:0] ext8;

  imm_extend_seq #(.DATA_W(DW), .ROT_STEP(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .ImmSrc(ImmSrc), .out_valid(out_valid), .out_ready(out_ready),
    .ExtImm(ExtImm), .bad_mode(bad_mode));

  imm_extend_seq #(.DATA_W(DW), .ROT_STEP(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .Instr(instr8), .ImmSrc(src8), .out_valid(out_valid8), .out_ready(out_ready8),
    .ExtImm(ext8), .bad_mode(bad8));

  typedef struct {
    logic [31:0] val;
    logic        bad;
    int          n;
    int          acc_cyc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ordy_mode = 1;
  logic        head_seen = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_val;
  logic        prev_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: value as an ARM decoder would define it, plus step count from the rotate amount.
  function automatic exp_t model(input logic [1:0] m, input logic [23:0] ins, input int step);
    exp_t e;
    logic [31:0] b;
    logic [63:0] d;
    logic signed [23:0] s;
    logic [7:0] bexp;
    int amt;
    int sv;
    e.val = 32'd0; e.bad = 1'b0; e.n = 0; e.acc_cyc = 0;
    case (m)
      2'b00: begin
        amt = 2 * int'(ins[11:8]);
        b = {24'd0, ins[7:0]};
        d = {b, b} >> amt;
        e.val = d[31:0];
        e.n = (amt + step - 1) / step;
      end
      2'b01: e.val = {20'd0, ins[11:0]};
      2'b10: begin
        s = ins;
        sv = s;
        e.val = 32'(sv * 4);
      end
      default: begin
`ifdef FP_IMM_EN
        bexp = ins[6] ? 8'(124 + int'(ins[5:4])) : 8'(128 + int'(ins[5:4]));
        e.val = {ins[7], bexp, ins[3:0], 19'd0};
`else
        bexp = 8'd0;
        e.val = {24'd0, bexp};
        e.bad = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (ordy_mode == 1) out_ready = 1'b1;
    else if (ordy_mode == 2) out_ready = 1'b0;
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: ordering, latency, hold stability and value of every presented result
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_stable", 64'(ExtImm), 64'(prev_val));
        chk("hold_bad", 64'(bad_mode), 64'(prev_bad));
      end
      if (out_valid) begin
        chk("valid_has_item", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          if (!head_seen) begin
            chk("latency", 64'(cyc), 64'(q[0].acc_cyc + q[0].n));
            head_seen = 1'b1;
          end
          if (out_ready) begin
            chk("ext_imm", 64'(ExtImm), 64'(q[0].val));
            chk("bad_mode", 64'(bad_mode), 64'(q[0].bad));
            void'(q.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_val  = ExtImm;
      prev_bad  = bad_mode;
    end else begin
      prev_hold = 1'b0;
      head_seen = 1'b0;
    end
  end

  task automatic send(input logic [1:0] m, input logic [23:0] ins, output int taken);
    exp_t e;
    int cnt;
    logic acc;
    in_valid = 1'b1; ImmSrc = m; Instr = ins;
    cnt = 0; acc = 1'b0;
    while (!acc && cnt < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("accept", 64'(acc), 64'd1);
    if (acc) begin
      e = model(m, ins, 2);
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    taken = cnt;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (q.size() != 0 && cnt < 300) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic run8(input logic [23:0] ins);
    exp_t e;
    int cnt;
    int lat;
    logic acc;
    e = model(2'b00, ins, 8);
    in_valid8 = 1'b1; instr8 = ins;
    cnt = 0; acc = 1'b0;
    while (!acc && cnt < 50) begin
      @(negedge clk);
      acc = in_ready8;
      @(posedge clk);
      #1;
      cnt++;
    end
    in_valid8 = 1'b0;
    chk("d8_accept", 64'(acc), 64'd1);
    lat = 0;
    @(negedge clk);
    while (!out_valid8 && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("d8_latency", 64'(lat), 64'(e.n));
    chk("d8_ext_imm", 64'(ext8), 64'(e.val));
    chk("d8_bad", 64'(bad8), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n = 1'b0; in_valid = 1'b0; Instr = 24'd0; ImmSrc = 2'b00;
    in_valid8 = 1'b0; instr8 = 24'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ext_imm", 64'(ExtImm), 64'd0);
    chk("rst_bad", 64'(bad_mode), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst8_out_valid", 64'(out_valid8), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // DP rotate 4 -> 0xFF000000 after four ROT cycles
    send(2'b00, 24'h0004FF, t);
    in_valid = 1'b0;
    drain();

    // Branch offsets back-to-back at one per cycle
    send(2'b10, 24'h800000, t);
    send(2'b10, 24'h000001, t);
    chk("b2b_rate_1", 64'(t), 64'd1);
    send(2'b10, 24'h7FFFFF, t);
    chk("b2b_rate_2", 64'(t), 64'd1);
    send(2'b01, 24'h000FFF, t);
    chk("b2b_rate_3", 64'(t), 64'd1);
    in_valid = 1'b0;
    drain();

    // Float immediate (or bad mode in the default build)
    send(2'b11, 24'h000070, t);
    send(2'b11, 24'h0000C5, t);
    in_valid = 1'b0;
    drain();

    // Backpressure: result held stable, no new accept
    ordy_mode = 2;
    @(posedge clk);
    #1;
    send(2'b01, 24'h000ABC, t);
    in_valid = 1'b1; Instr = 24'h000123; ImmSrc = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_ext_imm", 64'(ExtImm), 64'h0000_0ABC);
    end
    in_valid = 1'b0;
    ordy_mode = 1;
    drain();

    // Reset during rotation discards the in-flight item
    send(2'b00, 24'h000F55, t);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ext_imm", 64'(ExtImm), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_bad", 64'(bad_mode), 64'd0);
    q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("no_stale_out", 64'(out_valid), 64'd0);

    // Random traffic with random backpressure and gaps
    ordy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom_range(0, 3)), 24'($urandom), t);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    ordy_mode = 1;
    drain();

    // Coarse step: partial single step, then random DP items
    run8(24'h0001AB);
    for (int i = 0; i < 20; i++) run8(24'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
